// File: rtl/uzorak_ucitavac.sv
// uzorak_ucitavac: collects BROJ_ZNACAJKI feature words into one packed sample for the neuron stage
//   clk, rst             clock, asynchronous active-high reset
//   znacajka*            feature word stream (valid/ready, prva marks feature 0 of a sample)
//   uzorak*              packed sample, feature k at bits [SIRINA*k +: SIRINA], valid/ready handshake
//   greska_okvira        one-cycle pulse when prva arrives mid-sample (partial sample dropped)
//   broj_uzoraka         wrapping count of delivered samples
module uzorak_ucitavac #(
    parameter int BROJ_ZNACAJKI = 60,
    parameter int SIRINA = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SIRINA-1:0]                 znacajka,
    input  logic                              znacajka_valid,
    input  logic                              znacajka_prva,
    output logic                              znacajka_ready,
    output logic [BROJ_ZNACAJKI*SIRINA-1:0]   uzorak,
    output logic                              uzorak_valid,
    input  logic                              uzorak_ready,
    output logic                              greska_okvira,
    output logic [15:0]                       broj_uzoraka
);
    localparam int IW = BROJ_ZNACAJKI > 1 ? $clog2(BROJ_ZNACAJKI) : 1;
    typedef enum logic {PRIJEM, PUN} stanje_t;
    stanje_t stanje, sljedece;
    logic [IW-1:0] indeks, indeks_sl, upis_idx;
    logic prihvat, greska, zadnji;
    always_comb begin
        prihvat = znacajka_valid && znacajka_ready;
        greska = prihvat && znacajka_prva && indeks != '0;
        upis_idx = greska ? '0 : indeks;
        zadnji = prihvat && !greska && indeks == IW'(BROJ_ZNACAJKI - 1);
        sljedece = stanje == PRIJEM ? (zadnji ? PUN : PRIJEM) : (uzorak_ready ? PRIJEM : PUN);
        indeks_sl = !prihvat ? indeks : greska ? IW'(1) : zadnji ? '0 : indeks + IW'(1);
    end
    // ready is its own flop so it stays low while reset is held and rises on the first edge after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje <= PRIJEM;
            indeks <= '0;
            uzorak <= '0;
            greska_okvira <= 1'b0;
            broj_uzoraka <= '0;
            znacajka_ready <= 1'b0;
        end else begin
            stanje <= sljedece;
            indeks <= indeks_sl;
            if (prihvat)
                uzorak[upis_idx*SIRINA +: SIRINA] <= znacajka;
            greska_okvira <= greska;
            if (stanje == PUN && uzorak_ready)
                broj_uzoraka <= broj_uzoraka + 16'd1;
            znacajka_ready <= sljedece == PRIJEM;
        end
    end
    assign uzorak_valid = stanje == PUN;
endmodule

// File: tb/tb_uzorak_ucitavac.sv
// tb_uzorak_ucitavac: randomized and directed checks of uzorak_ucitavac against a queue-based sample model
module tb_uzorak_ucitavac;
    localparam int N = 60;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] zd = '0;
    logic zv = 1'b0, zp = 1'b0, ur = 1'b0;
    logic zr, uv, gr;
    logic [N*W-1:0] uz;
    logic [15:0] bu;
    int tests = 0, fails = 0;
    bit rand_ur = 1'b0;

    always #5 clk = ~clk;

    uzorak_ucitavac #(.BROJ_ZNACAJKI(N), .SIRINA(W)) dut (
        .clk(clk), .rst(rst),
        .znacajka(zd), .znacajka_valid(zv), .znacajka_prva(zp), .znacajka_ready(zr),
        .uzorak(uz), .uzorak_valid(uv), .uzorak_ready(ur),
        .greska_okvira(gr), .broj_uzoraka(bu)
    );

    // model: words of the current sample kept in a queue; a full queue becomes the held sample
    logic [W-1:0] q[$];
    bit m_full, m_rdy, m_err;
    logic [15:0] m_cnt;
    logic [N*W-1:0] m_uz;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_full = 0; m_rdy = 0; m_err = 0; m_cnt = 0; m_uz = '0;
        end else begin
            m_err = 0;
            if (m_full) begin
                if (ur) begin
                    m_full = 0;
                    m_cnt = m_cnt + 16'd1;
                end
            end else if (zv && m_rdy) begin
                if (zp && q.size() != 0) begin
                    m_err = 1;
                    q.delete();
                end
                q.push_back(zd);
                if (q.size() == N) begin
                    for (int k = 0; k < N; k++) m_uz[k*W +: W] = q[k];
                    m_full = 1;
                    q.delete();
                end
            end
            m_rdy = !m_full;
        end
    end

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", zr, 0);
            chk("rst_valid", uv, 0);
            chk("rst_greska", gr, 0);
            chk("rst_broj", bu, 0);
            chk("rst_uzorak", uz, 0);
        end else begin
            chk("ready", zr, m_rdy);
            chk("valid", uv, m_full);
            chk("greska", gr, m_err);
            chk("broj", bu, m_cnt);
            if (m_full) chk("uzorak", uz, m_uz);
        end
    end

    always @(negedge clk) if (rand_ur) ur = 1'($urandom_range(0, 1));

    // returns just after the edge that accepted the word
    task automatic push(input logic [W-1:0] d, input logic p, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            zv = 0;
        end
        @(negedge clk);
        zd = d; zp = p; zv = 1;
        while (!zr) begin
            if (++t > 200) begin
                tests++; fails++;
                $display("FAIL push_timeout: ready 0 expected 1");
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        zv = 0; zp = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #22 rst = 0;
        // basic fill
        ur = 1;
        for (int k = 0; k < N; k++) push(W'(k + 1), k == 0, 0);
        idle();
        chk("fill_lsb", uz[15:0], 16'h0001);
        chk("fill_msb", uz[959:944], 16'h003C);
        chk("fill_valid", uv, 1);
        @(negedge clk);
        chk("fill_broj", bu, 1);
        chk("fill_ready", zr, 1);
        // backpressure
        ur = 0;
        for (int k = 0; k < N; k++) push(W'($urandom), k == 0, 0);
        repeat (10) begin
            @(negedge clk);
            zd = W'($urandom); zp = 1'($urandom); zv = 1;
        end
        chk("bp_valid", uv, 1);
        chk("bp_ready", zr, 0);
        chk("bp_broj", bu, 1);
        @(negedge clk);
        ur = 1; zv = 0; zp = 0;
        @(negedge clk);
        ur = 0;
        chk("bp_broj2", bu, 2);
        // gapped input, no prva at sample start
        ur = 1;
        for (int k = 0; k < N; k++) push(W'(k + 1), 0, 1);
        idle();
        chk("gap_lsb", uz[15:0], 16'h0001);
        chk("gap_msb", uz[959:944], 16'h003C);
        chk("gap_valid", uv, 1);
        @(negedge clk);
        chk("gap_broj", bu, 3);
        // framing error
        for (int k = 0; k < 25; k++) push(W'(k + 100), k == 0, 0);
        push(16'hABCD, 1, 0);
        idle();
        chk("frm_pulse", gr, 1);
        @(negedge clk);
        chk("frm_clear", gr, 0);
        for (int k = 0; k < N - 1; k++) push(W'(k + 200), 0, 0);
        idle();
        chk("frm_lsb", uz[15:0], 16'hABCD);
        chk("frm_valid", uv, 1);
        @(negedge clk);
        // asynchronous reset mid-sample
        for (int k = 0; k < 30; k++) push(W'(k + 7), k == 0, 0);
        #3 rst = 1; zv = 0; zp = 0;
        #1;
        chk("arst_ready", zr, 0);
        chk("arst_valid", uv, 0);
        chk("arst_broj", bu, 0);
        chk("arst_uzorak", uz, 0);
        chk("arst_greska", gr, 0);
        @(negedge clk);
        #2 rst = 0;
        for (int k = 0; k < N; k++) push(W'($urandom), k == 0, 0);
        idle();
        @(negedge clk);
        chk("arst_broj1", bu, 1);
        // randomized traffic with random backpressure and occasional stray prva
        rand_ur = 1;
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < N; k++)
                push(W'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2));
        idle();
        rand_ur = 0;
        @(negedge clk);
        ur = 1;
        repeat (3) @(negedge clk);
        // sample counter wrap
        @(posedge clk);
        #1 force dut.broj_uzoraka = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.broj_uzoraka;
        for (int k = 0; k < N; k++) push(W'($urandom), k == 0, 0);
        idle();
        @(negedge clk);
        chk("wrap_broj", bu, 16'h0000);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
